// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer (main entry M, skid entry S). The memory side may
// stall without losing in-flight beats; ex_ready is taken straight from
// the state flop, so there is no combinational path from mem_ready.
module ex_mem_stage_reg #(
    parameter int ad_size = 32,
    parameter int d_size  = 32,
    parameter int rd_w    = 5
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_flush,
    input  logic               pipe_kill,
    input  logic [rd_w-1:0]    ex_rd,
    input  logic               ex_regwrite,
    input  logic               ex_memtoreg,
    input  logic               ex_mem_write,
    input  logic               ex_memread,
    input  logic [ad_size-1:0] ex_address,
    input  logic [d_size-1:0]  ex_data,

    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [rd_w-1:0]    mem_rd,
    output logic               mem_regwrite,
    output logic               mem_memtoreg,
    output logic               mem_mem_write,
    output logic               mem_memread,
    output logic [ad_size-1:0] mem_address,
    output logic [d_size-1:0]  mem_data,

    output logic [rd_w-1:0]    fwd_rd,
    output logic               fwd_regwrite
);

    // One beat of payload, stored exactly as presented by EX.
    typedef struct packed {
        logic [rd_w-1:0]    rd;
        logic               regwrite;
        logic               memtoreg;
        logic               mem_write;
        logic               memread;
        logic [ad_size-1:0] address;
        logic [d_size-1:0]  data;
    } payload_t;

    // Encoding mirrors the valid flags {m_v, s_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    state_t   state_q, state_d;
    payload_t m_q, m_d;
    payload_t s_q, s_d;
    payload_t in_beat;

    logic m_v;
    logic s_v;
    logic acc;
    logic pop;

    assign in_beat = '{
        rd:        ex_rd,
        regwrite:  ex_regwrite,
        memtoreg:  ex_memtoreg,
        mem_write: ex_mem_write,
        memread:   ex_memread,
        address:   ex_address,
        data:      ex_data
    };

    assign m_v = (state_q == FULL) || (state_q == SKID);
    assign s_v = (state_q == SKID);

    assign ex_ready = !s_v;
    assign acc      = ex_valid && ex_ready && !ex_flush;
    assign pop      = m_v && mem_ready;

    // State and payload registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    // Next-state and entry-load decisions; kill empties the stage but
    // leaves payload contents untouched.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (pipe_kill) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        m_d     = in_beat;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (pop && acc) begin
                        m_d = in_beat;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        s_d     = in_beat;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (pop) begin
                        m_d     = s_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Head outputs: control bits gated by m_v so an empty stage never writes.
    always_comb begin
        mem_valid     = m_v;
        mem_rd        = m_q.rd;
        mem_regwrite  = m_v && m_q.regwrite;
        mem_memtoreg  = m_v && m_q.memtoreg;
        mem_mem_write = m_v && m_q.mem_write;
        mem_memread   = m_v && m_q.memread;
        mem_address   = m_q.address;
        mem_data      = m_q.data;
        fwd_rd        = m_q.rd;
        fwd_regwrite  = m_v && m_q.regwrite;
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg: directed stimulus pushes the
// expected beats, a negedge monitor pops and compares every consumed beat.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_flush, pipe_kill;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memtoreg, ex_mem_write, ex_memread;
    logic [31:0] ex_address, ex_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_regwrite, mem_memtoreg, mem_mem_write, mem_memread;
    logic [31:0] mem_address, mem_data;
    logic [4:0]  fwd_rd;
    logic        fwd_regwrite;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw, mtr, mw, mr;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.ad_size(32), .d_size(32), .rd_w(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
        .pipe_kill(pipe_kill), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_mem_write(ex_mem_write),
        .ex_memread(ex_memread), .ex_address(ex_address), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_mem_write(mem_mem_write), .mem_memread(mem_memread),
        .mem_address(mem_address), .mem_data(mem_data),
        .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic rw, input logic mtr,
                         input logic mw, input logic mr,
                         input logic [31:0] addr, input logic [31:0] data);
        ex_valid     = 1'b1;
        ex_rd        = rd;
        ex_regwrite  = rw;
        ex_memtoreg  = mtr;
        ex_mem_write = mw;
        ex_memread   = mr;
        ex_address   = addr;
        ex_data      = data;
    endtask

    task automatic push(input logic [4:0] rd, input logic rw, input logic mtr,
                        input logic mw, input logic mr,
                        input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{rd: rd, rw: rw, mtr: mtr, mw: mw, mr: mr, addr: addr, data: data});
    endtask

    // Monitor: a beat is consumed at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            beat_t act;
            act = '{rd: mem_rd, rw: mem_regwrite, mtr: mem_memtoreg, mw: mem_mem_write,
                    mr: mem_memread, addr: mem_address, data: mem_data};
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {64'd0, act.addr, act.data}, 128'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat", 128'(act), 128'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_flush = 1'b0; pipe_kill = 1'b0;
        mem_ready = 1'b0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_mem_write = 1'b0;
        ex_memread = 1'b0; ex_address = '0; ex_data = '0;
        #12;
        chk("rst_ex_ready", 128'(ex_ready), 128'd1);
        chk("rst_mem_valid", 128'(mem_valid), 128'd0);
        chk("rst_outputs", 128'({mem_rd, mem_regwrite, mem_memtoreg, mem_mem_write,
                                 mem_memread, mem_address, mem_data, fwd_rd, fwd_regwrite}), 128'd0);
        rst = 1'b0;
        tick();

        // Streaming at one beat per cycle
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i));
            push(5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i));
            tick();
            chk("stream_addr", 128'(mem_address), 128'(32'h10 + 32'(4 * i)));
            chk("stream_ready", 128'(ex_ready), 128'd1);
        end
        ex_valid = 1'b0;
        tick();
        chk("stream_drain", 128'(mem_valid), 128'd0);

        // Skid buffer: A held, B into skid, C refused then accepted
        mem_ready = 1'b0;
        drive(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1);
        push(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1);
        tick();
        chk("skid_a_head", 128'(mem_address), 128'h40);
        drive(5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h2);
        push(5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h2);
        tick();
        chk("skid_not_ready", 128'(ex_ready), 128'd0);
        chk("skid_head_held", 128'(mem_address), 128'h40);
        drive(5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 32'h3);
        tick();
        chk("skid_c_refused", 128'(ex_ready), 128'd0);
        mem_ready = 1'b1;
        tick();
        chk("skid_b_head", 128'(mem_address), 128'h44);
        chk("skid_ready_again", 128'(ex_ready), 128'd1);
        push(5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 32'h3);
        tick();
        chk("skid_c_head", 128'(mem_address), 128'h48);
        ex_valid = 1'b0;
        tick();
        chk("skid_drain", 128'(mem_valid), 128'd0);

        // Flush drops the offered beat only
        mem_ready = 1'b0;
        drive(5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h55);
        ex_flush = 1'b1;
        tick();
        chk("flush_valid", 128'(mem_valid), 128'd0);
        chk("flush_write", 128'(mem_mem_write), 128'd0);
        chk("flush_ready", 128'(ex_ready), 128'd1);
        ex_flush = 1'b0;
        drive(5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 32'h84, 32'h66);
        push(5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 32'h84, 32'h66);
        mem_ready = 1'b1;
        tick();
        chk("flush_next_addr", 128'(mem_address), 128'h84);
        chk("flush_next_write", 128'(mem_mem_write), 128'd1);
        ex_valid = 1'b0;
        tick();

        // Kill from SKID: both held beats vanish
        mem_ready = 1'b0;
        drive(5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h7);
        tick();
        drive(5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h8);
        tick();
        chk("kill_in_skid", 128'(ex_ready), 128'd0);
        drive(5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h9);
        pipe_kill = 1'b1;
        tick();
        pipe_kill = 1'b0;
        ex_valid = 1'b0;
        chk("kill_valid", 128'(mem_valid), 128'd0);
        chk("kill_ready", 128'(ex_ready), 128'd1);
        chk("kill_fwd_rw", 128'(fwd_regwrite), 128'd0);
        mem_ready = 1'b1;
        tick();
        chk("kill_stays_empty", 128'(mem_valid), 128'd0);

        // Forwarding view of the head entry
        mem_ready = 1'b0;
        drive(5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEAD);
        push(5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEAD);
        tick();
        ex_valid = 1'b0;
        chk("fwd_rd", 128'(fwd_rd), 128'd9);
        chk("fwd_rw", 128'(fwd_regwrite), 128'd1);
        chk("fwd_memtoreg", 128'(mem_memtoreg), 128'd1);
        chk("fwd_data", 128'(mem_data), 128'hDEAD);
        mem_ready = 1'b1;
        tick();
        chk("fwd_rw_after_pop", 128'(fwd_regwrite), 128'd0);
        chk("fwd_rd_holds", 128'(mem_rd), 128'd9);

        // Asynchronous reset between edges while FULL
        mem_ready = 1'b0;
        drive(5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'hBEEF);
        tick();
        ex_valid = 1'b0;
        chk("arst_pre_valid", 128'(mem_valid), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(mem_valid), 128'd0);
        chk("arst_rd", 128'(mem_rd), 128'd0);
        chk("arst_fwd_rw", 128'(fwd_regwrite), 128'd0);
        chk("arst_addr", 128'(mem_address), 128'd0);
        tick();
        rst = 1'b0;
        tick();

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
